// File: rtl/cm_response_pkg.sv
// Shared encodings for the CM response encoder: frame header marker, event kinds, FSM states.
package cm_response_pkg;

    localparam logic [1:0] HDR_MARKER = 2'b11;

    typedef enum logic {
        KIND_NOTIF = 1'b0,
        KIND_ERROR = 1'b1
    } kind_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND_HDR  = 2'd2,
        SEND_STAT = 2'd3
    } state_e;

    // Queue entry: code already zero-extended/truncated to the 5-bit header field.
    typedef struct packed {
        kind_e       kind;
        logic [4:0]  code;
        logic [7:0]  status;
    } entry_t;

    function automatic logic [7:0] make_hdr(input entry_t e);
        return {HDR_MARKER, e.kind, e.code};
    endfunction

endpackage

// File: rtl/cm_response_queue.sv
// Synchronous FIFO of pending response entries; pop data is the head, valid while non-empty.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps the count.
module cm_response_queue #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
            if (do_pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/cm_response_encoder.sv
// Queues notification/error events and emits 2-byte frames (header, status) to a TX FIFO; 3/4 cycles strobe to bytes.
// Stalls while Full is high; events arriving with the queue full are dropped (counted when CM_DROP_COUNT_EN is defined).
module cm_response_encoder
    import cm_response_pkg::*;
#(
    parameter int CODE_WIDTH          = 4,
    parameter int CONFIG_STATUS_WIDTH = 8,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CODE_WIDTH-1:0]          Config_Notification,
    input  logic                           Config_Notification_Valid,
    input  logic [CODE_WIDTH-1:0]          Config_Error,
    input  logic                           Error_Valid,
    input  logic [CONFIG_STATUS_WIDTH-1:0] Config_Status,
    input  logic                           Full,
    output logic [7:0]                     TXD_Data,
    output logic                           Write_En,
    output logic                           Busy,
    output logic [7:0]                     Drop_Count
);
    state_e     state_q, state_d;
    entry_t     hold_q;
    entry_t     push_entry;
    entry_t     pop_entry;
    logic [4:0] ntf_code5, err_code5;
    logic [7:0] status8;
    logic       evt_vld;
    logic       q_pop, q_full, q_empty;
    logic       we_q, we_d;
    logic [7:0] txd_q, txd_d;

    if (CODE_WIDTH >= 5) begin : g_code_trunc
        assign ntf_code5 = Config_Notification[4:0];
        assign err_code5 = Config_Error[4:0];
    end else begin : g_code_ext
        assign ntf_code5 = {{(5-CODE_WIDTH){1'b0}}, Config_Notification};
        assign err_code5 = {{(5-CODE_WIDTH){1'b0}}, Config_Error};
    end

    if (CONFIG_STATUS_WIDTH >= 8) begin : g_stat_trunc
        assign status8 = Config_Status[7:0];
    end else begin : g_stat_ext
        assign status8 = {{(8-CONFIG_STATUS_WIDTH){1'b0}}, Config_Status};
    end

    assign evt_vld = Error_Valid || Config_Notification_Valid;

    // An error wins over a same-cycle notification.
    always_comb begin
        push_entry        = '0;
        push_entry.status = status8;
        if (Error_Valid) begin
            push_entry.kind = KIND_ERROR;
            push_entry.code = err_code5;
        end else begin
            push_entry.kind = KIND_NOTIF;
            push_entry.code = ntf_code5;
        end
    end

    cm_response_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (evt_vld),
        .push_dat_i (push_entry),
        .pop_i      (q_pop),
        .pop_dat_o  (pop_entry),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    always_comb begin
        state_d = state_q;
        q_pop   = 1'b0;
        we_d    = 1'b0;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                if (!q_empty) state_d = LOAD;
            end
            LOAD: begin
                q_pop   = 1'b1;
                state_d = SEND_HDR;
            end
            SEND_HDR: begin
                if (!Full) begin
                    we_d    = 1'b1;
                    txd_d   = make_hdr(hold_q);
                    state_d = SEND_STAT;
                end
            end
            SEND_STAT: begin
                if (!Full) begin
                    we_d    = 1'b1;
                    txd_d   = hold_q.status;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            we_q    <= 1'b0;
            txd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            txd_q   <= txd_d;
            if (q_pop) hold_q <= pop_entry;
        end
    end

    assign Write_En = we_q;
    assign TXD_Data = txd_q;
    assign Busy     = (state_q != IDLE) || !q_empty;

`ifdef CM_DROP_COUNT_EN
    logic [7:0] drop_q;
    logic [1:0] drops;
    logic [8:0] drop_sum;

    // Up to two drops per cycle: the losing notification plus an event hitting a full queue.
    assign drops    = {1'b0, Error_Valid && Config_Notification_Valid} + {1'b0, evt_vld && q_full};
    assign drop_sum = {1'b0, drop_q} + {7'b0, drops};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= 8'h00;
        else        drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign Drop_Count = drop_q;
`else
    assign Drop_Count = 8'h00;
`endif

endmodule

// File: tb/tb_cm_response_encoder.sv
// Directed self-checking bench for cm_response_encoder (frame format, latency, backpressure, drops, reset).
module tb_cm_response_encoder;

`ifdef CM_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Config_Notification;
    logic       Config_Notification_Valid;
    logic [3:0] Config_Error;
    logic       Error_Valid;
    logic [7:0] Config_Status;
    logic       Full;
    logic [7:0] TXD_Data;
    logic       Write_En;
    logic       Busy;
    logic [7:0] Drop_Count;

    int checks = 0;
    int errors = 0;
    logic [7:0] wr_q [$];

    cm_response_encoder dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .Config_Notification       (Config_Notification),
        .Config_Notification_Valid (Config_Notification_Valid),
        .Config_Error              (Config_Error),
        .Error_Valid               (Error_Valid),
        .Config_Status             (Config_Status),
        .Full                      (Full),
        .TXD_Data                  (TXD_Data),
        .Write_En                  (Write_En),
        .Busy                      (Busy),
        .Drop_Count                (Drop_Count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && Write_En) wr_q.push_back(TXD_Data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        Config_Notification       = '0;
        Config_Notification_Valid = 1'b0;
        Config_Error              = '0;
        Error_Valid               = 1'b0;
        Config_Status             = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        Full = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        wr_q.delete();
    endtask

    // Drives one notification for a single sampling edge; returns just after that edge.
    task automatic send_ntf(input logic [3:0] code, input logic [7:0] st);
        Config_Notification       = code;
        Config_Notification_Valid = 1'b1;
        Config_Status             = st;
        step(1);
        clear_inputs();
    endtask

    int we_cnt;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        Full = 1'b0;
        #1;
        chk("rst_we", Write_En, 0);
        chk("rst_txd", TXD_Data, 8'h00);
        chk("rst_busy", Busy, 0);
        chk("rst_drop", Drop_Count, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        wr_q.delete();

        // Basic frame and latency: header 3 cycles, status 4 cycles after the strobe.
        send_ntf(4'h3, 8'hA5);
        chk("lat_busy", Busy, 1);
        step(2);
        chk("lat_no_we_early", Write_En, 0);
        step(1);
        chk("lat_hdr_we", Write_En, 1);
        chk("lat_hdr_dat", TXD_Data, 8'hC3);
        step(1);
        chk("lat_st_we", Write_En, 1);
        chk("lat_st_dat", TXD_Data, 8'hA5);
        step(1);
        chk("lat_we_low", Write_En, 0);
        chk("lat_txd_hold", TXD_Data, 8'hA5);
        chk("lat_busy_done", Busy, 0);

        // Simultaneous error + notification: only the error frame.
        do_reset();
        Config_Error              = 4'h2;
        Error_Valid               = 1'b1;
        Config_Notification       = 4'h1;
        Config_Notification_Valid = 1'b1;
        Config_Status             = 8'h5A;
        step(1);
        clear_inputs();
        step(8);
        chk("both_nbytes", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("both_hdr", wr_q[0], 8'hE2);
            chk("both_stat", wr_q[1], 8'h5A);
        end
        chk("both_drop", Drop_Count, DC_EN ? 1 : 0);

        // Full held during SEND_HDR for 10 cycles.
        do_reset();
        Full = 1'b1;
        send_ntf(4'h7, 8'h3C);
        step(2);
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (Write_En) we_cnt++;
        end
        chk("full_no_we", we_cnt, 0);
        chk("full_busy", Busy, 1);
        Full = 1'b0;
        step(1);
        chk("full_hdr_we", Write_En, 1);
        chk("full_hdr_dat", TXD_Data, 8'hC7);
        step(1);
        chk("full_st_dat", TXD_Data, 8'h3C);

        // Holding register occupied by a stalled frame, then 6 notifications into a 4-deep queue.
        do_reset();
        Full = 1'b1;
        send_ntf(4'h0, 8'h80);
        step(2);
        for (int i = 1; i <= 6; i++) begin
            Config_Notification       = 4'(i);
            Config_Notification_Valid = 1'b1;
            Config_Status             = 8'(8'h10 + i);
            step(1);
        end
        clear_inputs();
        chk("b2b_drop", Drop_Count, DC_EN ? 2 : 0);
        Full = 1'b0;
        step(40);
        chk("b2b_nbytes", wr_q.size(), 10);
        if (wr_q.size() == 10) begin
            chk("b2b_prime_hdr", wr_q[0], 8'hC0);
            chk("b2b_prime_st", wr_q[1], 8'h80);
            for (int i = 1; i <= 4; i++) begin
                chk($sformatf("b2b_hdr%0d", i), wr_q[2*i], 32'(8'hC0 | i));
                chk($sformatf("b2b_st%0d", i), wr_q[2*i+1], 32'(8'h10 + i));
            end
        end
        chk("b2b_busy", Busy, 0);

        // Reset between header and status.
        do_reset();
        send_ntf(4'h5, 8'h77);
        step(3);
        chk("rstmid_hdr_we", Write_En, 1);
        chk("rstmid_hdr_dat", TXD_Data, 8'hC5);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we", Write_En, 0);
        chk("rstmid_txd", TXD_Data, 8'h00);
        chk("rstmid_busy", Busy, 0);
        wr_q.delete();
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("rstmid_no_stat", wr_q.size(), 0);
        chk("rstmid_busy_after", Busy, 0);

        // 300+ drops saturate the counter.
        do_reset();
        Full = 1'b1;
        for (int i = 0; i < 300; i++) begin
            Config_Error              = 4'hE;
            Error_Valid               = 1'b1;
            Config_Notification       = 4'h9;
            Config_Notification_Valid = 1'b1;
            Config_Status             = 8'(i);
            step(1);
        end
        clear_inputs();
        chk("sat_drop", Drop_Count, DC_EN ? 255 : 0);
        chk("sat_busy", Busy, 1);
        do_reset();
        chk("sat_drop_rst", Drop_Count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cm_response_encoder.md
CM_RESPONSE_ENCODER -- requirements
Module: cm_response_encoder

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 4, width of notification and error codes.
REQ-002 SHALL have parameter CONFIG_STATUS_WIDTH, default 8, width of the configuration status snapshot.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4 (power of two), number of pending response entries.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports: Config_Notification in CODE_WIDTH, notification code; Config_Notification_Valid in 1, one-cycle notification strobe.
REQ-006 SHALL have ports: Config_Error in CODE_WIDTH, error code; Error_Valid in 1, one-cycle error strobe.
REQ-007 SHALL have port Config_Status in CONFIG_STATUS_WIDTH, live configuration status.
REQ-008 SHALL have ports: Full in 1, TX FIFO full; TXD_Data out 8, byte to TX FIFO; Write_En out 1, TX FIFO push strobe.
REQ-009 SHALL have ports: Busy out 1, frame in progress or queue non-empty; Drop_Count out 8, dropped-event count (macro-dependent).

Function
REQ-010 SHALL encode each event as a 2-byte frame: header byte {2'b11, kind, code zero-extended to 5 bits}, kind 0 = notification, 1 = error; then the status byte (Config_Status snapshot, zero-extended or truncated to 8 bits).
REQ-011 SHALL capture {kind, code, Config_Status} into the queue on the clock edge that samples a valid strobe.
REQ-012 SHALL store only the error entry when both strobes are high in the same cycle; the notification counts as dropped.
REQ-013 SHALL drop an event that arrives while the queue is full; queue contents are unchanged.
REQ-014 SHALL use FSM states IDLE, LOAD, SEND_HDR, SEND_STAT.
- IDLE -> LOAD when the queue is non-empty.
- LOAD pops the head entry into a holding register -> SEND_HDR.
- SEND_HDR: if Full is low, registers Write_En=1 with the header -> SEND_STAT; otherwise stays.
- SEND_STAT: same Full rule for the status byte -> IDLE.
REQ-015 SHALL register Write_En and TXD_Data; Write_En is high for exactly one cycle per byte and is never high while Full was high in the preceding cycle.
REQ-016 SHALL hold TXD_Data at the last written byte when Write_En is low.
REQ-017 SHALL keep latency at 3 cycles from strobe to header Write_En and 4 to status Write_En, given an empty queue, IDLE state and Full low.
REQ-018 SHALL handle a simultaneous push and pop in the same cycle, keeping the occupancy count correct; wrap-around uses pointer modulo QUEUE_DEPTH.
REQ-019 SHALL drive Busy = (state != IDLE) OR queue non-empty.

Reset
REQ-020 SHALL, on rst_n low, asynchronously force state IDLE, empty the queue, and clear Write_En=0, TXD_Data=0, Drop_Count=0 and Busy=0.
REQ-021 SHALL abandon any frame interrupted by reset; no trailing status byte is emitted after reset.

Configuration
REQ-022 SHALL, with CM_DROP_COUNT_EN defined, increment Drop_Count by one per dropped event (REQ-012, REQ-013), saturating at 255.
REQ-023 SHALL, without CM_DROP_COUNT_EN, tie Drop_Count to 0 and synthesise no counter logic.

Structure
REQ-024 SHALL place the header marker 2'b11, the kind encodings and the state encodings in shared package cm_response_pkg.
REQ-025 SHALL implement the queue as sub-module cm_response_queue (synchronous FIFO with push, pop, full, empty).

Verification
REQ-026 SHALL cover: notification code 4'h3 with status 8'hA5, Full low -> header 8'hC3 in cycle 3, then 8'hA5 in cycle 4.
REQ-027 SHALL cover: error code 4'h2 and notification 4'h1 in the same cycle -> only frame 8'hE2, status; Drop_Count=1 (with macro).
REQ-028 SHALL cover: Full held high for 10 cycles during SEND_HDR -> no Write_En; header is written on the cycle after Full falls.
REQ-029 SHALL cover: 6 back-to-back notifications with Full high -> 4 frames later emitted in order; Drop_Count=2 with macro, 0 without.
REQ-030 SHALL cover: rst_n pulsed low between header and status -> no status byte, Busy=0, queue empty.
REQ-031 SHALL cover: 300 dropped events with the macro defined -> Drop_Count saturates at 255.
